// File: rtl/result_packer.sv
// Packs LANES consecutive WIDTH-bit pipeline results into one word and queues it in a DEPTH-entry FIFO.
// Optional per-entry parity output is enabled by defining PACKER_PARITY_EN.
module result_packer #(
    parameter int WIDTH = 4,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_q,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH*LANES-1:0]     out_data,
    output logic [$clog2(LANES+1)-1:0] out_lanes,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
`ifdef PACKER_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    localparam int IW = $clog2(LANES);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LANES + 1);
    localparam int DW = WIDTH * LANES;

    function automatic logic even_parity(input logic [DW-1:0] d);
        return ^d;
    endfunction

    logic [IW-1:0] idx_q,      idx_d;
    logic [DW-1:0] pack_q,     pack_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic [DW-1:0] mem_data_q  [DEPTH];
    logic [LW-1:0] mem_lanes_q [DEPTH];
`ifdef PACKER_PARITY_EN
    logic          mem_par_q   [DEPTH];
`endif

    logic [DW-1:0] merged_s;
    logic [LW-1:0] push_lanes_s;
    logic          complete_s, push_s, pop_s, full_s, wr_en_s, drop_s;

    // Merge the same-cycle sample into the pack register and decide push/pop/drop.
    always_comb begin
        merged_s = pack_q;
        for (int l = 0; l < LANES; l++) begin
            merged_s[l*WIDTH +: WIDTH] = (in_valid && (idx_q == IW'(l))) ? in_q
                                                                        : pack_q[l*WIDTH +: WIDTH];
        end
        complete_s   = in_valid && (idx_q == IW'(LANES - 1));
        push_s       = complete_s || (flush && ((idx_q != {IW{1'b0}}) || in_valid));
        push_lanes_s = complete_s ? LW'(LANES) : (LW'(idx_q) + LW'(in_valid));
        pop_s        = (count_q != {CW{1'b0}}) && out_ready;
        full_s       = (count_q == CW'(DEPTH));
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        wr_en_s      = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
    end

    // Next-state for lane counter, pack register, FIFO pointers and loss tracking.
    always_comb begin
        idx_d      = idx_q;
        pack_d     = pack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_s) begin
            idx_d  = {IW{1'b0}};
            pack_d = {DW{1'b0}};
        end else if (in_valid) begin
            idx_d  = idx_q + {{(IW-1){1'b0}}, 1'b1};
            pack_d = merged_s;
        end else begin
            idx_d  = idx_q;
            pack_d = pack_q;
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        if (drop_s) begin
            overflow_d = 1'b1;
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : (drop_cnt_q + 8'd1);
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= {IW{1'b0}};
            pack_q     <= {DW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by count.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_data_q[wr_ptr_q]  <= merged_s;
            mem_lanes_q[wr_ptr_q] <= push_lanes_s;
`ifdef PACKER_PARITY_EN
            mem_par_q[wr_ptr_q]   <= even_parity(merged_s);
`endif
        end
    end

    assign out_valid = (count_q != {CW{1'b0}});
    assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : {DW{1'b0}};
    assign out_lanes = out_valid ? mem_lanes_q[rd_ptr_q] : {LW{1'b0}};
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
`ifdef PACKER_PARITY_EN
    assign out_parity = out_valid ? mem_par_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer (WIDTH=4, LANES=4, DEPTH=4).
// Covers the optional out_parity port when PACKER_PARITY_EN is defined.
module tb_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_q;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_lanes;
    logic        overflow;
    logic [7:0]  drop_cnt;
`ifdef PACKER_PARITY_EN
    logic        out_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    result_packer #(.WIDTH(4), .LANES(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_q      (in_q),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lanes (out_lanes),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef PACKER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        in_valid = 1'b1;
        in_q     = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
        check({tag, "_drop"},  32'(drop_cnt),  32'd0);
    endtask

    task automatic expect_head(input string tag, input logic [15:0] d, input logic [2:0] l);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_lanes"}, 32'(out_lanes), 32'(l));
`ifdef PACKER_PARITY_EN
        check({tag, "_par"},   32'(out_parity), 32'(^d));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] drain_exp [4];
    logic [15:0] sfp_exp   [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_q      = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        idle_outputs("rst");
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_lanes", 32'(out_lanes), 32'd0);
`ifdef PACKER_PARITY_EN
        check("rst_par", 32'(out_parity), 32'd0);
`endif

        // Full word with out_ready high: visible one cycle, then popped
        out_ready = 1'b1;
        send(4'h1);
        send(4'h2);
        send(4'h3);
        check("full_early_valid", 32'(out_valid), 32'd0);
        send(4'h4);
        expect_head("full", 16'h4321, 3'd4);
        tick();
        check("full_gone", 32'(out_valid), 32'd0);

        // Partial flush, then a following full word
        send(4'hA);
        send(4'hB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_head("pflush", 16'h00BA, 3'd2);
        send(4'h5);
        check("pflush_popped", 32'(out_valid), 32'd0);
        send(4'h6);
        send(4'h7);
        send(4'h8);
        expect_head("after_flush", 16'h8765, 3'd4);
        tick();

        // Overflow: 20 samples with backpressure, fifth word dropped
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(4'(i));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_cnt",  32'(drop_cnt), 32'd1);
        drain_exp[0] = 16'h3210;
        drain_exp[1] = 16'h7654;
        drain_exp[2] = 16'hBA98;
        drain_exp[3] = 16'hFEDC;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_head($sformatf("drain%0d", i), drain_exp[i], 3'd4);
            tick();
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        idle_outputs("rst2");
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(4'(i));
        for (int i = 0; i < 3; i++) send(4'h5);
        out_ready = 1'b1;
        send(4'h5);
        out_ready = 1'b0;
        check("sim_ovf",  32'(overflow), 32'd0);
        check("sim_drop", 32'(drop_cnt), 32'd0);
        sfp_exp[0] = 16'h7654;
        sfp_exp[1] = 16'hBA98;
        sfp_exp[2] = 16'hFEDC;
        sfp_exp[3] = 16'h5555;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_head($sformatf("sim%0d", i), sfp_exp[i], 3'd4);
            tick();
        end
        check("sim_empty", 32'(out_valid), 32'd0);

        // Flush together with the completing sample: exactly one word
        send(4'h1);
        send(4'h2);
        send(4'h3);
        flush = 1'b1;
        send(4'h4);
        flush = 1'b0;
        expect_head("fc", 16'h4321, 3'd4);
        tick();
        check("fc_no_extra", 32'(out_valid), 32'd0);

        // Reset mid-word discards the partial data
        send(4'h9);
        send(4'h9);
        rst = 1'b1;
        tick();
        idle_outputs("mid_rst");
        rst = 1'b0;
        tick();
        idle_outputs("post_rst");
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        expect_head("rst_word", 16'h4321, 3'd4);
        tick();
        check("rst_word_only", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
